// File: rtl/sad_min_select.sv
// sad_min_select: per-partition running minimum of the full-search SAD array.
// Stage 1 registers each candidate. Stage 2 compares it against the stored
// minima and updates them.
// Optional build macro: SUB8X8_PARTITION_EN adds the 4x8 and 8x4 partitions.
//
// Handshake: sad_valid qualifies the SAD buses, the counts and sad_last in the
// same cycle. There is no ready/backpressure, so the block accepts every valid
// sample while SEARCH. result_valid is a one-cycle pulse.

// One group of N same-width partitions: stage-1 SAD register plus min trackers.
module sad_min_track #(
  parameter int N    = 1,
  parameter int W    = 8,
  parameter int MV_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              cap,
  input  logic              upd,
  input  logic [N*W-1:0]    sad_in,
  input  logic [MV_W-1:0]   s1_mv,
  output logic [N*W-1:0]    best_sad,
  output logic [N*MV_W-1:0] best_mv
);
  logic [N*W-1:0] s1_sad;

  // Stage 1: hold the candidate SADs for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   s1_sad <= '0;
    else if (cap) s1_sad <= sad_in;
  end

  // Stage 2: a strict less-than keeps the earliest position on ties. clear wins over upd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_sad <= '1;
      best_mv  <= '0;
    end else if (clear) begin
      best_sad <= '1;
      best_mv  <= '0;
    end else if (upd) begin
      for (int i = 0; i < N; i++) begin
        if (s1_sad[i*W +: W] < best_sad[i*W +: W]) begin
          best_sad[i*W +: W]       <= s1_sad[i*W +: W];
          best_mv[i*MV_W +: MV_W]  <= s1_mv;
        end
      end
    end
  end
endmodule

module sad_min_select #(
  parameter int COL_W = 5,
  parameter int ROW_W = 7,
  parameter int MV_W  = COL_W + ROW_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             search_start,
  input  logic             sad_valid,
  input  logic             sad_last,
  input  logic [COL_W-1:0] search_column_count,
  input  logic [ROW_W-1:0] search_row_count,
  input  logic [223:0]     SAD8x8,
  input  logic [119:0]     SAD8x16,
  input  logic [119:0]     SAD16x8,
  input  logic [63:0]      SAD16x16,
  input  logic [33:0]      SAD16X32,
  input  logic [33:0]      SAD32x16,
  input  logic [17:0]      SAD32x32,
`ifdef SUB8X8_PARTITION_EN
  input  logic [415:0]     SAD4x8,
  input  logic [415:0]     SAD8x4,
  output logic [415:0]     best_sad_4x8,
  output logic [415:0]     best_sad_8x4,
  output logic [105*MV_W-1:0] best_mv,
`else
  output logic [41*MV_W-1:0]  best_mv,
`endif
  output logic [223:0]     best_sad_8x8,
  output logic [119:0]     best_sad_8x16,
  output logic [119:0]     best_sad_16x8,
  output logic [63:0]      best_sad_16x16,
  output logic [33:0]      best_sad_16x32,
  output logic [33:0]      best_sad_32x16,
  output logic [17:0]      best_sad_32x32,
  output logic             busy,
  output logic             result_valid,
  output logic [1:0]       fsm_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, DONE = 2'd2} state_t;

  state_t            state, state_nxt;
  logic              cap, upd;
  logic              s1_valid, s1_last;
  logic [MV_W-1:0]   s1_mv;

  // A start in the same cycle as a sample drops that sample.
  assign cap = (state == SEARCH) && sad_valid && !search_start;
  assign upd = s1_valid && !search_start;
  assign fsm_state = state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and status outputs. A start from any state restarts the search.
  always_comb begin
    state_nxt    = state;
    busy         = (state == SEARCH);
    result_valid = (state == DONE);
    if (search_start) begin
      state_nxt = SEARCH;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        SEARCH:  if (s1_valid && s1_last) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage-1 control and position register. Each tracker holds its own SAD copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_mv    <= '0;
    end else begin
      s1_valid <= cap;
      if (cap) begin
        s1_last <= sad_last;
        s1_mv   <= {search_row_count, search_column_count};
      end
    end
  end

  sad_min_track #(.N(16), .W(14), .MV_W(MV_W)) u_8x8 (
    .clk(clk), .rst_n(rst_n), .clear(search_start), .cap(cap), .upd(upd),
    .sad_in(SAD8x8), .s1_mv(s1_mv), .best_sad(best_sad_8x8),
    .best_mv(best_mv[0*MV_W +: 16*MV_W]));
  sad_min_track #(.N(8), .W(15), .MV_W(MV_W)) u_8x16 (
    .clk(clk), .rst_n(rst_n), .clear(search_start), .cap(cap), .upd(upd),
    .sad_in(SAD8x16), .s1_mv(s1_mv), .best_sad(best_sad_8x16),
    .best_mv(best_mv[16*MV_W +: 8*MV_W]));
  sad_min_track #(.N(8), .W(15), .MV_W(MV_W)) u_16x8 (
    .clk(clk), .rst_n(rst_n), .clear(search_start), .cap(cap), .upd(upd),
    .sad_in(SAD16x8), .s1_mv(s1_mv), .best_sad(best_sad_16x8),
    .best_mv(best_mv[24*MV_W +: 8*MV_W]));
  sad_min_track #(.N(4), .W(16), .MV_W(MV_W)) u_16x16 (
    .clk(clk), .rst_n(rst_n), .clear(search_start), .cap(cap), .upd(upd),
    .sad_in(SAD16x16), .s1_mv(s1_mv), .best_sad(best_sad_16x16),
    .best_mv(best_mv[32*MV_W +: 4*MV_W]));
  sad_min_track #(.N(2), .W(17), .MV_W(MV_W)) u_16x32 (
    .clk(clk), .rst_n(rst_n), .clear(search_start), .cap(cap), .upd(upd),
    .sad_in(SAD16X32), .s1_mv(s1_mv), .best_sad(best_sad_16x32),
    .best_mv(best_mv[36*MV_W +: 2*MV_W]));
  sad_min_track #(.N(2), .W(17), .MV_W(MV_W)) u_32x16 (
    .clk(clk), .rst_n(rst_n), .clear(search_start), .cap(cap), .upd(upd),
    .sad_in(SAD32x16), .s1_mv(s1_mv), .best_sad(best_sad_32x16),
    .best_mv(best_mv[38*MV_W +: 2*MV_W]));
  sad_min_track #(.N(1), .W(18), .MV_W(MV_W)) u_32x32 (
    .clk(clk), .rst_n(rst_n), .clear(search_start), .cap(cap), .upd(upd),
    .sad_in(SAD32x32), .s1_mv(s1_mv), .best_sad(best_sad_32x32),
    .best_mv(best_mv[40*MV_W +: 1*MV_W]));
`ifdef SUB8X8_PARTITION_EN
  sad_min_track #(.N(32), .W(13), .MV_W(MV_W)) u_4x8 (
    .clk(clk), .rst_n(rst_n), .clear(search_start), .cap(cap), .upd(upd),
    .sad_in(SAD4x8), .s1_mv(s1_mv), .best_sad(best_sad_4x8),
    .best_mv(best_mv[41*MV_W +: 32*MV_W]));
  sad_min_track #(.N(32), .W(13), .MV_W(MV_W)) u_8x4 (
    .clk(clk), .rst_n(rst_n), .clear(search_start), .cap(cap), .upd(upd),
    .sad_in(SAD8x4), .s1_mv(s1_mv), .best_sad(best_sad_8x4),
    .best_mv(best_mv[73*MV_W +: 32*MV_W]));
`endif
endmodule

// File: doc/sad_min_select.md
Name: sad_min_select

Overview:
- Sits directly downstream of the basic-layer full-search SAD array.
- Each search cycle the array presents one candidate position (search_column_count, search_row_count) and the SADs of every partition at that position.
- This block tracks, per partition, the minimum SAD and the position that produced it.
- At end of search it presents the best SAD and best motion-vector position per partition to the mode-decision stage.

Parameters:
- COL_W, 5, width of search column count.
- ROW_W, 7, width of search row count.
- MV_W, COL_W+ROW_W (12), packed position width per partition, {row, col}.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- search_start  in  1  one-cycle pulse: clear all minima, begin a new search
- sad_valid  in  1  SAD buses and counts valid this cycle
- sad_last  in  1  qualifies the final candidate of the search (used only with sad_valid)
- search_column_count  in  COL_W  candidate column
- search_row_count  in  ROW_W  candidate row
- SAD8x8  in  224  16 x 14b
- SAD8x16  in  120  8 x 15b
- SAD16x8  in  120  8 x 15b
- SAD16x16  in  64  4 x 16b
- SAD16X32  in  34  2 x 17b
- SAD32x16  in  34  2 x 17b
- SAD32x32  in  18  1 x 18b
- best_sad_8x8 / 8x16 / 16x8 / 16x16 / 16x32 / 32x16 / 32x32  out  same widths as matching input  running/final minima
- best_mv  out  41*MV_W (492)  packed positions; order 8x8[0..15], 8x16[0..7], 16x8[0..7], 16x16[0..3], 16x32[0..1], 32x16[0..1], 32x32[0], index 0 at LSBs
- busy  out  1  high in SEARCH
- result_valid  out  1  one-cycle pulse, final results stable
- Packing for all buses: partition index 0 at LSBs.

Behaviour:
- Reset: all best_sad_* = all-ones, best_mv = 0, busy = 0, result_valid = 0, FSM = IDLE, pipeline valid = 0.
- FSM states: IDLE, SEARCH, DONE.
  - IDLE -> SEARCH on search_start.
  - SEARCH -> DONE when stage-2 processes a sample tagged last.
  - DONE -> IDLE after one cycle.
  - search_start in any state (including mid-SEARCH) -> SEARCH. It clears all minima to all-ones and best_mv to 0, and flushes stage-1 valid.
- Stage 1 (register): when FSM = SEARCH and sad_valid and not search_start, capture all SAD buses, counts and sad_last; set s1_valid. Otherwise s1_valid = 0.
  - sad_valid outside SEARCH is ignored.
  - A search_start coincident with sad_valid wins; that sample is dropped.
- Stage 2 (compare/update): when s1_valid, for each partition, if s1_sad < best_sad (strict unsigned) then best_sad <= s1_sad and best_mv <= {s1_row, s1_col}.
  - Ties keep the earlier position.
  - Comparisons are independent per partition and all happen in the same cycle.
- Latency: a candidate presented at cycle N is reflected in best_* at N+2.
  - If sad_last is presented at N, result_valid pulses at N+2, coincident with the final update being visible.
  - busy drops at N+2; best_* are held until the next search_start.
- Minimum cannot underflow. All-ones initial value guarantees the first valid sample always updates, unless its SAD is all-ones (then best_mv stays 0).
- Gaps in sad_valid within SEARCH are allowed; no timeout.
- sad_last without sad_valid has no effect.
- Async reset mid-search aborts; no result_valid is generated.

Optional Feature:
- Macro SUB8X8_PARTITION_EN.
- Defined:
  - adds inputs SAD4x8 (416, 32 x 13b) and SAD8x4 (416, 32 x 13b);
  - adds outputs best_sad_4x8 and best_sad_8x4 (416 each);
  - adds 64 trackers; best_mv widens to 105*MV_W (1260), with 4x8[0..31] then 8x4[0..31] appended above the 32x32 entry.
  - Same pipeline, latency and tie rules.
- Undefined: those ports and trackers do not exist; best_mv is 492 bits.

Test Plan:
- Reset then idle: best_sad_32x32 = 18'h3FFFF, best_mv = 0, result_valid = 0; sad_valid pulses in IDLE cause no change.
- Start, then 3 candidates (col,row) = (0,0),(1,0),(2,0) with SAD32x32 = 500, 300, 400, last on the third -> result_valid exactly 2 cycles after the third; best_sad_32x32 = 300; mv = {7'd0, 5'd1}.
- Tie: SAD16x16[0] = 100 at (3,5) then 100 at (4,5) -> mv stays {5,3}. Per-partition independence: SAD8x8[15] minimum at (31,127) while SAD8x8[0] minimum at (0,0) -> both reported correctly.
- search_start asserted mid-search coincident with sad_valid (SAD32x32 = 10) -> sample dropped, minima all-ones; next candidate SAD32x32 = 900 becomes best.
- rst_n low for one cycle mid-SEARCH -> outputs return to reset values; no result_valid pulse.
- With SUB8X8_PARTITION_EN defined: SAD4x8[31] = 7 at (9,2) among larger values -> best_sad_4x8[31] = 7; its mv slot (index 72) = {2,9}.
